// File: rtl/debounce_multi_majority.sv
// Per-channel synchronise + early-threshold window debouncer with holdoff, edge pulses and long-press flag.
// Output toggles SYNC_STAGES+THRESHOLD edges after a clean step; all outputs registered; enable=0 freezes channel state.
module debounce_multi_majority #(
  parameter int CHANNELS    = 4,
  parameter int WINDOW      = 20,
  parameter int THRESHOLD   = 10,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF     = 8,
  parameter int LONG_PRESS  = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] button_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] long_press,
  output logic [CHANNELS-1:0] held
);

  localparam int WW = $clog2(WINDOW + 1);
  localparam int DW = $clog2(THRESHOLD + 1);
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int LW = $clog2(LONG_PRESS + 1);

  typedef enum logic {ST_COUNT = 1'b0, ST_HOLD = 1'b1} state_t;

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]                  s;

  // The synchroniser keeps running while enable is low so resuming sees a current level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d, wcnt_inc;
    logic [DW-1:0] dcnt_q, dcnt_d, dcnt_inc;
    logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
    logic [LW-1:0] lcnt_q, lcnt_d, lcnt_inc;
    logic          out_q, out_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          lp_q, lp_d;
    logic          held_q, held_d;
    logic          mis, win_open, toggle, expire, hold_done;

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q <= ST_COUNT;
        wcnt_q  <= '0;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        lcnt_q  <= '0;
        out_q   <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        lp_q    <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        wcnt_q  <= wcnt_d;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
        lcnt_q  <= lcnt_d;
        out_q   <= out_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        lp_q    <= lp_d;
        held_q  <= held_d;
      end
    end

    // An idle window has wcnt=dcnt=0, so the same increment path covers opening a window.
    always_comb begin
      mis       = s[g] ^ out_q;
      win_open  = (wcnt_q != '0);
      wcnt_inc  = wcnt_q + 1'b1;
      dcnt_inc  = dcnt_q + DW'(mis);
      hcnt_inc  = hcnt_q + 1'b1;
      lcnt_inc  = lcnt_q + 1'b1;
      toggle    = enable && (state_q == ST_COUNT) && mis && (dcnt_inc == DW'(THRESHOLD));
      expire    = enable && (state_q == ST_COUNT) && win_open && !toggle &&
                  (wcnt_inc == WW'(WINDOW));
      hold_done = (HOLDOFF > 0) && enable && (state_q == ST_HOLD) &&
                  (hcnt_inc == HW'(HOLDOFF));
    end

    always_comb begin
      state_d = state_q;
      if (toggle && (HOLDOFF > 0)) begin
        state_d = ST_HOLD;
      end else if (hold_done) begin
        state_d = ST_COUNT;
      end
    end

    always_comb begin
      wcnt_d = wcnt_q;
      dcnt_d = dcnt_q;
      hcnt_d = hcnt_q;
      lcnt_d = lcnt_q;
      out_d  = out_q;
      held_d = held_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      lp_d   = 1'b0;
      if (enable) begin
        if (state_q == ST_COUNT) begin
          if (toggle) begin
            out_d  = ~out_q;
            wcnt_d = '0;
            dcnt_d = '0;
            rise_d = ~out_q;
            fall_d = out_q;
          end else if (expire) begin
            wcnt_d = '0;
            dcnt_d = '0;
          end else if (win_open) begin
            wcnt_d = wcnt_inc;
            dcnt_d = dcnt_inc;
          end else if (mis) begin
            wcnt_d = WW'(1);
            dcnt_d = DW'(1);
          end
        end else begin
          hcnt_d = hold_done ? '0 : hcnt_inc;
        end

        if (toggle && out_q) begin
          lcnt_d = '0;
          held_d = 1'b0;
        end else if (out_q && (lcnt_q != LW'(LONG_PRESS))) begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc == LW'(LONG_PRESS)) begin
            lp_d   = 1'b1;
            held_d = 1'b1;
          end
        end
      end
    end

    assign button_out[g] = out_q;
    assign rise_pulse[g] = rise_q;
    assign fall_pulse[g] = fall_q;
    assign long_press[g] = lp_q;
    assign held[g]       = held_q;
  end

endmodule

// File: tb/tb_debounce_multi_majority.sv
// Bench for debounce_multi_majority: timestamp-based reference model checked every cycle plus directed latency checks.
module tb_debounce_multi_majority;
  localparam int CH = 4, WIN = 20, TH = 10, SYNC = 2, HO = 8, LP = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic [CH-1:0] button_in = '0;
  logic [CH-1:0] button_out, rise_pulse, fall_pulse, long_press, held;

  int errors = 0;
  int checks = 0;

  debounce_multi_majority #(
    .CHANNELS(CH), .WINDOW(WIN), .THRESHOLD(TH), .SYNC_STAGES(SYNC),
    .HOLDOFF(HO), .LONG_PRESS(LP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .button_in(button_in),
    .button_out(button_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .long_press(long_press), .held(held)
  );

  always #5 clk = ~clk;

  // Reference model: windows and holdoffs tracked as timestamps in enabled-edge time.
  logic [CH-1:0] m_syn [SYNC];
  bit m_valid = 0;
  int m_ecyc;
  bit m_out[CH], m_rise[CH], m_fall[CH], m_lp[CH], m_held[CH];
  bit m_open[CH], m_inhold[CH], m_reached[CH];
  int m_start[CH], m_mism[CH], m_hold_end[CH], m_press_start[CH];

  always @(posedge clk) begin : model
    logic [CH-1:0] ms;
    bit old, tog, mis;
    ms = m_syn[SYNC-1];
    if (!reset) begin
      for (int k = 0; k < SYNC; k++) m_syn[k] = '0;
      m_ecyc = 0;
      for (int c = 0; c < CH; c++) begin
        m_out[c] = 0; m_rise[c] = 0; m_fall[c] = 0; m_lp[c] = 0; m_held[c] = 0;
        m_open[c] = 0; m_inhold[c] = 0; m_reached[c] = 0;
        m_start[c] = 0; m_mism[c] = 0; m_hold_end[c] = 0; m_press_start[c] = 0;
      end
      m_valid = 1;
    end else begin
      for (int k = SYNC - 1; k > 0; k--) m_syn[k] = m_syn[k-1];
      m_syn[0] = button_in;
      for (int c = 0; c < CH; c++) begin
        m_rise[c] = 0; m_fall[c] = 0; m_lp[c] = 0;
      end
      if (enable) begin
        m_ecyc++;
        for (int c = 0; c < CH; c++) begin
          old = m_out[c];
          tog = 0;
          if (m_inhold[c]) begin
            if (m_ecyc == m_hold_end[c]) m_inhold[c] = 0;
          end else begin
            mis = (ms[c] != old);
            if (!m_open[c]) begin
              if (mis) begin m_open[c] = 1; m_start[c] = m_ecyc; m_mism[c] = 1; end
            end else if (mis) begin
              m_mism[c]++;
            end
            if (m_open[c] && mis && m_mism[c] == TH) tog = 1;
            else if (m_open[c] && (m_ecyc - m_start[c] + 1 == WIN)) m_open[c] = 0;
            if (tog) begin
              m_open[c] = 0;
              m_out[c]  = !old;
              m_rise[c] = !old;
              m_fall[c] = old;
              if (HO > 0) begin m_inhold[c] = 1; m_hold_end[c] = m_ecyc + HO; end
            end
          end
          if (old) begin
            if (tog) begin m_held[c] = 0; m_reached[c] = 0; end
            else if (!m_reached[c] && (m_ecyc - m_press_start[c] == LP)) begin
              m_lp[c] = 1; m_held[c] = 1; m_reached[c] = 1;
            end
          end else if (tog) begin
            m_press_start[c] = m_ecyc;
          end
        end
      end
    end
  end

  task automatic cmp_vec(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    logic [CH-1:0] eo, er, ef, el, eh;
    if (m_valid) begin
      for (int c = 0; c < CH; c++) begin
        eo[c] = m_out[c]; er[c] = m_rise[c]; ef[c] = m_fall[c];
        el[c] = m_lp[c];  eh[c] = m_held[c];
      end
      cmp_vec("button_out", button_out, eo);
      cmp_vec("rise_pulse", rise_pulse, er);
      cmp_vec("fall_pulse", fall_pulse, ef);
      cmp_vec("long_press", long_press, el);
      cmp_vec("held", held, eh);
      cmp_vec("rise_and_fall", rise_pulse & fall_pulse, '0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Counts edges until the selected output bit is 1 (sampled 1 time unit after each edge).
  task automatic wait_bit(input int sel, input int ch, input int lim, output int n);
    logic v;
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(posedge clk); #1;
      case (sel)
        0: v = button_out[ch];
        1: v = !button_out[ch];
        2: v = long_press[ch];
        default: v = 1'b0;
      endcase
      if (v) begin n = i; break; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int n, rises;
  int bounce_left[CH];

  initial begin
    // Reset held low for 3 cycles with inputs toggling.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      button_in = 4'(i % 2 ? 4'b1010 : 4'b0101);
    end
    button_in = '0;
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("out_after_reset", int'(button_out), 0);
    chk("held_after_reset", int'(held), 0);
    idle(5);

    // Clean step on ch0.
    button_in[0] = 1'b1;
    wait_bit(0, 0, 40, n);
    chk("ch0_step_latency", n, SYNC + TH);
    chk("ch0_rise", int'(rise_pulse[0]), 1);
    chk("others_quiet", int'(button_out[3:1]), 0);
    @(posedge clk); #1;
    chk("ch0_rise_one_cycle", int'(rise_pulse[0]), 0);
    idle(30);

    // Bounce on ch1: 1,0 alternating for 20 cycles, then stable 1.
    for (int i = 0; i < 20; i++) begin
      button_in[1] = (i % 2 == 0);
      @(posedge clk); #1;
      if (button_out[1] && n >= 0 && i < 19) n = n;
      #1;
    end
    button_in[1] = 1'b1;
    idle(60);
    chk("ch1_bounce_out", int'(button_out[1]), 1);

    // Exact toggle edge for the bounce and single rise.
    button_in[1] = 1'b0;
    idle(60);
    rises = 0;
    for (int i = 1; i <= 60; i++) begin
      button_in[1] = (i <= 20) ? ((i % 2) == 1) : 1'b1;
      @(posedge clk); #1;
      if (rise_pulse[1]) begin
        rises++;
        if (rises == 1) chk("ch1_bounce_toggle_edge", i, 21);
      end
      #1;
    end
    chk("ch1_bounce_single_rise", rises, 1);

    // Long press on ch2.
    button_in[2] = 1'b1;
    wait_bit(0, 2, 40, n);
    chk("ch2_rise_latency", n, SYNC + TH);
    wait_bit(2, 2, 200, n);
    chk("ch2_long_press_edge", n, LP);
    chk("ch2_held_set", int'(held[2]), 1);
    @(posedge clk); #1;
    chk("ch2_long_press_one_cycle", int'(long_press[2]), 0);
    #1;
    idle(40);
    chk("ch2_held_kept", int'(held[2]), 1);
    button_in[2] = 1'b0;
    wait_bit(1, 2, 40, n);
    chk("ch2_fall_latency", n, SYNC + TH);
    chk("ch2_fall_pulse", int'(fall_pulse[2]), 1);
    chk("ch2_held_cleared", int'(held[2]), 0);
    #1;
    idle(30);

    // Freeze ch3 mid-window after 4 counted mismatches.
    button_in[3] = 1'b1;
    idle(SYNC + 4);
    enable = 1'b0;
    idle(30);
    chk("ch3_frozen_out", int'(button_out[3]), 0);
    enable = 1'b1;
    wait_bit(0, 3, 40, n);
    chk("ch3_resume_latency", n, TH - 4);
    #1;
    idle(30);

    // Simultaneous steps on all channels, then reset inside holdoff.
    button_in = '0;
    idle(150);
    chk("all_low", int'(button_out), 0);
    button_in = '1;
    wait_bit(0, 0, 40, n);
    chk("all_step_latency", n, SYNC + TH);
    chk("all_rise", int'(rise_pulse), 15);
    #1;
    idle(4);
    reset = 1'b0;
    idle(2);
    chk("reset_in_hold_out", int'(button_out), 0);
    chk("reset_in_hold_rise", int'(rise_pulse), 0);
    reset = 1'b1;
    wait_bit(0, 0, 40, n);
    chk("post_reset_latency", n, SYNC + TH);
    chk("post_reset_all", int'(button_out), 15);
    #1;

    // Randomised traffic with bounce bursts, enable gaps and rare resets.
    for (int c = 0; c < CH; c++) bounce_left[c] = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      for (int c = 0; c < CH; c++) begin
        if (bounce_left[c] > 0) begin
          bounce_left[c]--;
          button_in[c] = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 99) == 0) begin
          bounce_left[c] = int'($urandom_range(5, 40));
        end else if ($urandom_range(0, 59) == 0) begin
          button_in[c] = !button_in[c];
        end
      end
      enable = ($urandom_range(0, 19) != 0);
      reset  = ($urandom_range(0, 1499) != 0);
    end
    reset = 1'b1;
    enable = 1'b1;
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
